// File: rtl/bitwave_pe_grid_pkg.sv
// pe_grid_pkg: shared state type, default parameters and width helpers
// for the bitwave_pe_grid bit-serial PE grid.
package pe_grid_pkg;

  localparam int DEF_ROWS    = 4;
  localparam int DEF_COLS    = 32;
  localparam int DEF_LANES   = 8;
  localparam int DEF_ACT_W   = 8;
  localparam int DEF_SHIFT_W = 3;
  localparam int DEF_ACC_W   = 32;

  // Grid control states; HOLD is only reachable with the shadow buffer built in.
  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Width of one shifted, sign-qualified partial sum: lane sum growth,
  // maximum significance shift, plus one bit so negating the most negative
  // sum cannot overflow.
  function automatic int ps_width(input int act_w, input int lanes, input int shift_w);
    return act_w + $clog2(lanes) + (1 << shift_w);
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitwave_pe_grid_if.sv
// bitwave_pe_grid_if: beat input and row-drain output bundle of the PE grid.
// slave = the grid itself, master = the fetch path / writeback side driving it.
interface bitwave_pe_grid_if
  import pe_grid_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int LANES   = DEF_LANES,
  parameter int ACT_W   = DEF_ACT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int ACC_W   = DEF_ACC_W
) ();

  localparam int ROW_W = idx_width(ROWS);

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  logic [ROWS*LANES*ACT_W-1:0]   act;
  logic [COLS*LANES-1:0]         wcol;
  logic [COLS-1:0]               wsign;
  logic [COLS*SHIFT_W-1:0]       shift;
  logic                          out_valid;
  logic                          out_ready;
  logic [ROW_W-1:0]              out_row;
  logic [COLS*ACC_W-1:0]         out_data;
  logic                          busy;

  modport slave (
    input  in_valid, in_last, act, wcol, wsign, shift, out_ready,
    output in_ready, out_valid, out_row, out_data, busy
  );

  modport master (
    output in_valid, in_last, act, wcol, wsign, shift, out_ready,
    input  in_ready, out_valid, out_row, out_data, busy
  );

endinterface

// File: rtl/bitwave_pe_grid_bs_pe.sv
// bitwave_bs_pe: one bit-serial processing element. Sums the activations
// selected by its weight bit-column, applies the column significance and
// sign-plane negation, and accumulates over a tile.
// Optional shadow result register when PE_GRID_DBUF_EN is defined.
module bitwave_bs_pe
  import pe_grid_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int ACT_W   = DEF_ACT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [LANES*ACT_W-1:0]   act,
  input  logic [LANES-1:0]         wbits,
  input  logic                     wsign,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     load,
  input  logic                     first,
`ifdef PE_GRID_DBUF_EN
  input  logic                     sh_load,
`endif
  output logic [ACC_W-1:0]         result
);

  localparam int PS_W = ps_width(ACT_W, LANES, SHIFT_W);

  logic signed [ACT_W-1:0] act_l [LANES];
  logic signed [PS_W-1:0]  lane_sum;
  logic signed [PS_W-1:0]  shifted;
  logic signed [PS_W-1:0]  ps;
  logic [ACC_W-1:0]        ps_ext;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign act_l[l] = act[l*ACT_W +: ACT_W];
  end

  // Partial sum of this beat: masked lane sum, significance shift, sign plane.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each statement sees the one before; flops use '<=' only.
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (wbits[l]) lane_sum = lane_sum + PS_W'(act_l[l]);
    end
    shifted = lane_sum <<< shift;
    ps      = wsign ? -shifted : shifted;
  end

  // Sign-extend to the accumulator; the sum wraps modulo 2^ACC_W.
  assign ps_ext = ACC_W'(ps);
  assign acc_d  = load ? (first ? ps_ext : acc_q + ps_ext) : acc_q;

  // Tile accumulator.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the accumulators are discrete flops rather than a RAM, so they take the async reset like any other state.
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end

`ifdef PE_GRID_DBUF_EN
  logic [ACC_W-1:0] shadow_q;

  // Shadow copy of a finished tile; captures the same-edge final sum when loading.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        shadow_q <= '0;
    else if (sh_load) shadow_q <= acc_d;
  end

  assign result = shadow_q;
`else
  assign result = acc_q;
`endif

endmodule

// File: rtl/bitwave_pe_grid.sv
// bitwave_pe_grid: ROWS x COLS bit-serial PE grid. Accepts bit-column beats
// while accumulating a tile, then drains one row per valid/ready beat.
// PE_GRID_DBUF_EN: drain from per-PE shadow buffers so the next tile can
// accumulate concurrently (adds the HOLD state).
module bitwave_pe_grid
  import pe_grid_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int LANES   = DEF_LANES,
  parameter int ACT_W   = DEF_ACT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input logic               clk,
  input logic               rstn,
  bitwave_pe_grid_if.slave  bus
);

  localparam int ROW_W = idx_width(ROWS);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             busy_q, busy_d;
  logic             first_q, first_d;

  logic             accept;
  logic             last_row;
  logic             drain_hs;
  logic             drain_done;
`ifdef PE_GRID_DBUF_EN
  logic             sh_load;
`endif

  logic [ACC_W-1:0]      results [ROWS][COLS];
  logic [COLS*ACC_W-1:0] out_data;

  assign accept     = bus.in_valid & in_ready_q;
  assign last_row   = (row_q == ROW_W'(ROWS - 1));
  assign drain_hs   = out_valid_q & bus.out_ready;
  assign drain_done = drain_hs & last_row;

  // Control registers: state, handshake outputs, row counter, tile flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ACC;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      row_q       <= row_d;
      busy_q      <= busy_d;
      first_q     <= first_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    row_d       = row_q;
    first_d     = first_q;
`ifdef PE_GRID_DBUF_EN
    sh_load     = 1'b0;
`endif

    // The beat after a final bit-column opens a fresh accumulation.
    if (accept) first_d = bus.in_last;

`ifdef PE_GRID_DBUF_EN
    // The drain runs from the shadow, independent of accumulation.
    if (drain_hs) begin
      if (last_row) begin
        out_valid_d = 1'b0;
        row_d       = '0;
      end else begin
        row_d = row_q + 1'b1;
      end
    end

    case (state_q)
      ACC: begin
        if (accept && bus.in_last) begin
          if (!out_valid_q || drain_done) begin
            sh_load     = 1'b1;
            out_valid_d = 1'b1;
            row_d       = '0;
          end else begin
            state_d    = HOLD;
            in_ready_d = 1'b0;
          end
        end
      end
      HOLD: begin
        if (!out_valid_q) begin
          sh_load     = 1'b1;
          out_valid_d = 1'b1;
          row_d       = '0;
          state_d     = ACC;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d    = ACC;
        in_ready_d = 1'b1;
      end
    endcase
`else
    case (state_q)
      ACC: begin
        if (accept && bus.in_last) begin
          state_d     = DRAIN;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          row_d       = '0;
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          if (last_row) begin
            state_d     = ACC;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            row_d       = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = ACC;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        row_d       = '0;
      end
    endcase
`endif

    busy_d = !first_d | out_valid_d | (state_d == HOLD);
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      bitwave_bs_pe #(
        .LANES   (LANES),
        .ACT_W   (ACT_W),
        .SHIFT_W (SHIFT_W),
        .ACC_W   (ACC_W)
      ) u_pe (
        .clk     (clk),
        .rstn    (rstn),
        .act     (bus.act[r*LANES*ACT_W +: LANES*ACT_W]),
        .wbits   (bus.wcol[c*LANES +: LANES]),
        .wsign   (bus.wsign[c]),
        .shift   (bus.shift[c*SHIFT_W +: SHIFT_W]),
        .load    (accept),
        .first   (first_q),
`ifdef PE_GRID_DBUF_EN
        .sh_load (sh_load),
`endif
        .result  (results[r][c])
      );
    end
  end

  // Output mux: presented row's results, zero while nothing is presented.
  always_comb begin
    out_data = '0;
    if (out_valid_q) begin
      for (int c = 0; c < COLS; c++) out_data[c*ACC_W +: ACC_W] = results[row_q][c];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = row_q;
  assign bus.out_data  = out_data;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bitwave_pe_grid.sv
// tb_bitwave_pe_grid: directed and randomized tiles against a behavioural
// model of the PE grid arithmetic; drains checked row by row.
module tb_bitwave_pe_grid;

  localparam int ROWS    = 4;
  localparam int COLS    = 32;
  localparam int LANES   = 8;
  localparam int ACT_W   = 8;
  localparam int SHIFT_W = 3;
  localparam int ACC_W   = 32;

  logic clk = 1'b0;
  logic rstn;

  bitwave_pe_grid_if #(
    .ROWS(ROWS), .COLS(COLS), .LANES(LANES),
    .ACT_W(ACT_W), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W)
  ) bus ();

  bitwave_pe_grid #(
    .ROWS(ROWS), .COLS(COLS), .LANES(LANES),
    .ACT_W(ACT_W), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Current beat, kept as plain numbers.
  int               b_act   [ROWS][LANES];
  logic [LANES-1:0] b_w     [COLS];
  bit               b_sign  [COLS];
  int               b_shift [COLS];

  // Reference: per-PE running sum and queue of expected drained values.
  int unsigned m_acc [ROWS][COLS];
  bit          m_first = 1'b1;
  int unsigned exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_uniform(input int a, input logic [LANES-1:0] w, input bit s, input int sh);
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++) b_act[r][l] = a;
    for (int c = 0; c < COLS; c++) begin
      b_w[c] = w; b_sign[c] = s; b_shift[c] = sh;
    end
  endtask

  task automatic set_random();
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++) b_act[r][l] = int'($urandom_range(0, 255)) - 128;
    for (int c = 0; c < COLS; c++) begin
      b_w[c]     = LANES'($urandom);
      b_sign[c]  = ($urandom_range(0, 3) == 0);
      b_shift[c] = int'($urandom_range(0, 7));
    end
  endtask

  task automatic drive_beat(input bit last);
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++)
        bus.act[(r*LANES+l)*ACT_W +: ACT_W] = ACT_W'(b_act[r][l]);
    for (int c = 0; c < COLS; c++) begin
      bus.wcol[c*LANES +: LANES]       = b_w[c];
      bus.wsign[c]                     = b_sign[c];
      bus.shift[c*SHIFT_W +: SHIFT_W]  = SHIFT_W'(b_shift[c]);
    end
    bus.in_last  = last;
    bus.in_valid = 1'b1;
  endtask

  // Plain-arithmetic model of one accepted beat.
  function automatic void model_beat(input bit last);
    int          s;
    int unsigned ps;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        s = 0;
        for (int l = 0; l < LANES; l++) if (b_w[c][l]) s += b_act[r][l];
        ps = s * (1 << b_shift[c]);
        if (b_sign[c]) ps = -ps;
        m_acc[r][c] = m_first ? ps : m_acc[r][c] + ps;
      end
    end
    if (last)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) exp_q.push_back(m_acc[r][c]);
    m_first = last;
  endfunction

  // Present one beat at a negedge and wait (bounded) for its acceptance.
  task automatic send_beat(input bit last);
    drive_beat(last);
    for (int t = 0; !bus.in_ready; t++) begin
      if (t == 50) begin
        check("accept_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    model_beat(last);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Drain one tile: optional stall on one row, optional random ready gaps.
  task automatic drain_tile(input int stall_row, input int stall_n, input bit rnd);
    int unsigned expv [COLS];
    int          n;
    for (int r = 0; r < ROWS; r++) begin
      for (int t = 0; !bus.out_valid; t++) begin
        if (t == 100) begin
          check("drain_timeout", bus.out_valid, 1);
          return;
        end
        @(negedge clk);
      end
      for (int c = 0; c < COLS; c++) expv[c] = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
      n = (r == stall_row) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= n; s++) begin
        check("out_valid_row", bus.out_valid, 1);
        check($sformatf("out_row r%0d", r), bus.out_row, r);
        for (int c = 0; c < COLS; c++)
          check($sformatf("data r%0d c%0d", r, c), bus.out_data[c*ACC_W +: ACC_W], expv[c]);
`ifndef PE_GRID_DBUF_EN
        check("in_ready_drain", bus.in_ready, 0);
`endif
        bus.out_ready = (s == n);
        @(negedge clk);
      end
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.act       = '0;
    bus.wcol      = '0;
    bus.wsign     = '0;
    bus.shift     = '0;
    bus.out_ready = 1'b0;
    rstn          = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_out_data", |bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single-beat tile: act=3, all lanes, no shift -> 24 everywhere.
    set_uniform(3, 8'hFF, 1'b0, 0);
    check("t1_valid_before", bus.out_valid, 0);
    send_beat(1'b1);
    check("t1_valid_after", bus.out_valid, 1);
    check("t1_busy", bus.busy, 1);
`ifndef PE_GRID_DBUF_EN
    check("t1_in_ready", bus.in_ready, 0);
`endif
    check("t1_col0", bus.out_data[0 +: ACC_W], 24);
    check("t1_col31", bus.out_data[31*ACC_W +: ACC_W], 24);
    drain_tile(-1, 0, 1'b0);
    check("t1_in_ready_after", bus.in_ready, 1);
    check("t1_busy_after", bus.busy, 0);
    check("t1_valid_after_drain", bus.out_valid, 0);
    check("t1_data_after_drain", |bus.out_data, 0);

    // Eight bit-columns, sign plane last: -127 + 128 = 1.
    for (int k = 0; k < 8; k++) begin
      set_uniform(-1, 8'h01, (k == 7), k);
      send_beat(k == 7);
    end
    check("t2_col0", bus.out_data[0 +: ACC_W], 1);
    drain_tile(-1, 0, 1'b0);

    // Random 3-beat tile, consumer stalls 5 cycles on row 2.
    for (int k = 0; k < 3; k++) begin
      set_random();
      send_beat(k == 2);
    end
    drain_tile(2, 5, 1'b0);

    // Random tiles with random consumer gaps.
    for (int t = 0; t < 6; t++) begin
      int len;
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        set_random();
        send_beat(k == len - 1);
      end
      drain_tile(-1, 0, 1'b1);
    end

    // Wrap: reach 0x7FFFFFFF, then add 1.
    set_uniform(127, 8'hFF, 1'b0, 7);
    for (int i = 0; i < 16513; i++) send_beat(1'b0);
    set_uniform(127, 8'hFF, 1'b0, 0);
    send_beat(1'b0);
    set_uniform(0, 8'hFF, 1'b0, 0);
    for (int r = 0; r < ROWS; r++) b_act[r][0] = 7;
    send_beat(1'b0);
    for (int r = 0; r < ROWS; r++) b_act[r][0] = 1;
    send_beat(1'b1);
    check("wrap_col0", bus.out_data[0 +: ACC_W], 32'h8000_0000);
    drain_tile(-1, 0, 1'b0);

    // Reset in the middle of a drain, at row 1.
    for (int k = 0; k < 2; k++) begin
      set_random();
      send_beat(k == 1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("mid_row", bus.out_row, 1);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_row", bus.out_row, 0);
    check("mid_rst_out_data", |bus.out_data, 0);
    check("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    m_first = 1'b1;
    @(negedge clk);
    set_random();
    send_beat(1'b1);
    drain_tile(-1, 0, 1'b0);

`ifdef PE_GRID_DBUF_EN
    // Back-to-back single-beat tiles with the consumer stalled.
    set_random();
    send_beat(1'b1);
    check("db_valid", bus.out_valid, 1);
    check("db_in_ready", bus.in_ready, 1);
    set_random();
    send_beat(1'b1);
    check("db_hold_in_ready", bus.in_ready, 0);
    check("db_hold_busy", bus.busy, 1);
    drain_tile(-1, 0, 1'b0);
    drain_tile(-1, 0, 1'b1);
    check("db_in_ready_after", bus.in_ready, 1);
    check("db_busy_after", bus.busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitwave_pe_grid.md
# bitwave_pe_grid

Parametrised bit-serial PE grid: ROWS×COLS processing elements, one activation group broadcast per row and one weight bit-column per grid column. Each PE accumulates shifted, sign-qualified partial sums over a tile of bit-columns. When a tile completes, the grid drains its results one row per beat over a valid/ready port. It sits between the activation/weight fetch path (zero-column skipping upstream) and the output writeback.

## Interface
- ROWS, 4, grid rows (activation groups)
- COLS, 32, grid columns (weight columns)
- LANES, 8, activations per group / bits per weight bit-column
- ACT_W, 8, signed activation width
- SHIFT_W, 3, bit-significance offset width
- ACC_W, 32, accumulator width (≥ ACT_W+clog2(LANES)+2^SHIFT_W)
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  beat presented
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_last  in  1  beat is final bit-column of the tile
- act  in  ROWS*LANES*ACT_W  row r lane l at [(r*LANES+l)*ACT_W +: ACT_W]
- wcol  in  COLS*LANES  column c lane l at bit c*LANES+l
- wsign  in  COLS  1 = this bit-column is the weight sign plane (subtract)
- shift  in  COLS*SHIFT_W  per-column significance of the bit-column
- out_valid  out  1  row result presented
- out_ready  in  1  consumer accepts row
- out_row  out  clog2(ROWS)  index of presented row
- out_data  out  COLS*ACC_W  column c at [c*ACC_W +: ACC_W], signed
- busy  out  1  any tile in flight or draining

## Operation
- Per accepted beat, PE(r,c): ps = Σ_l (wcol[c][l] ? sext(act[r][l]) : 0); ps <<= shift[c]; if wsign[c], ps = −ps.
- First accepted beat of a tile: acc = ps; later beats: acc += ps. Wraps modulo 2^ACC_W, no saturation.
- States: ACC (accepting), DRAIN (presenting rows 0..ROWS-1 in order), HOLD (dbuf only).
- ACC: in_ready=1. Accepting in_last → DRAIN, out_row=0; results frozen including the last beat.
- DRAIN: in_ready=0; out_row advances on each out_valid&out_ready; the handshake at row ROWS-1 → ACC with first-beat flag set.
- out_data stable while out_valid&!out_ready.
- busy=1 from the first accepted beat of a tile until the final drain handshake.
- Reset mid-tile or mid-drain abandons all work; no partial output.

## Timing
- Reset values: in_ready=1, out_valid=0, out_row=0, out_data=0, busy=0, all accumulators 0, state ACC.
- Accumulator updates on the edge that accepts the beat; in_ready is registered and does not depend on in_valid or in_last.
- out_valid rises the cycle after the in_last beat is accepted; minimum tile-to-tile gap is ROWS cycles when out_ready=1.
- In non-dbuf mode, a beat presented during the final drain handshake waits one cycle: in_ready rises the cycle after.

## Configuration
- PE_GRID_DBUF_EN defined: shadow result buffer per PE.
  - in_last accepted with shadow empty: shadow ← final sums on the same edge, drain reads shadow, in_ready stays 1, and the next tile accumulates concurrently.
  - in_last accepted with shadow occupied: go to HOLD with in_ready=0. Once the drain completes, copy to shadow next edge and resume ACC.
  - Drain completion and a new in_last accepted on the same edge: copy allowed; the freed shadow takes priority.
- Undefined: no shadow; ACC/DRAIN only as above.

## Structure
- Package pe_grid_pkg: state enum (ACC, DRAIN, HOLD), partial-sum width function, default parameter constants.
- Sub-module bitwave_bs_pe: one PE (lane sum, shift, negate, accumulator, optional shadow), instantiated ROWS×COLS by generate. Grid top holds the FSM, row counter and output mux.

## Test plan
- ROWS=4, LANES=8, all act=3, wcol=0xFF, shift=0, wsign=0, single beat with last → every out_data column=24, rows 0..3 in order, out_valid rises 1 cycle after accept.
- 8-beat tile: shift=0..7, wsign only on beat 7, act=−1, wcol=0x01 → acc = −1·(1+2+…+64) + 128 = 1.
- out_ready low 5 cycles on row 2 → out_row=2 and out_data held constant; in_ready=0 throughout (non-dbuf).
- Accumulation of 0x7FFFFFFF plus a partial sum of 1 with ACC_W=32 → 0x80000000, no saturation.
- rstn pulsed low mid-drain at row 1 → outputs return to reset values immediately; next tile's first beat starts a fresh acc.
- PE_GRID_DBUF_EN, back-to-back 1-beat tiles with out_ready=0 → second in_last accepted, HOLD, in_ready=0; release out_ready → tile 1 rows, then tile 2 rows, no lost beats.
